// File: rtl/rgmii_pkg.sv
// Shared constants and state encoding for the RGMII/UDP transmit path.
package rgmii_pkg;

  localparam int unsigned PKT_HDR_BYTES = 4;
  localparam int unsigned PKT_MIN_BYTES = 5;

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_HDR,
    PKT_DATA,
    PKT_PAD
  } pkt_state_e;

endpackage

// File: rtl/axis_udp_packetizer.sv
// Frames an 8-bit sample stream into fixed-length UDP payloads with a 32-bit sequence header.
// Optional frame/pad statistics counters are built when PACKETIZER_STATS_EN is defined.
module axis_udp_packetizer
  import rgmii_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = 11,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic [PAYLOAD_WIDTH-1:0] payload_bytes_i,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
  output logic [31:0]              seq_num_o,
  output logic                     busy_o,
  output logic                     pad_pulse_o,
`ifdef PACKETIZER_STATS_EN
  output logic [31:0]              pkt_cnt_o,
  output logic [31:0]              pad_cnt_o,
`endif
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready
);

  pkt_state_e               state_q, state_d;
  logic [31:0]              seq_q, seq_d;
  logic [PAYLOAD_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [PAYLOAD_WIDTH-1:0] len_q, len_d;
  logic [TIMEOUT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                     last_beat;
  logic                     frame_end;
  logic [7:0]               hdr_byte;
  logic                     unused_tlast;

  // Input tlast carries no framing meaning here; frames are length-defined.
  assign unused_tlast = s_axis_tlast;

  assign seq_num_o = seq_q;
  assign busy_o    = (state_q != PKT_IDLE);
  assign last_beat = (byte_cnt_q == len_q - PAYLOAD_WIDTH'(1));

  always_comb begin
    hdr_byte = seq_q[7:0];
    case (byte_cnt_q[1:0])
      2'd0:    hdr_byte = seq_q[31:24];
      2'd1:    hdr_byte = seq_q[23:16];
      2'd2:    hdr_byte = seq_q[15:8];
      default: hdr_byte = seq_q[7:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= PKT_IDLE;
      seq_q       <= '0;
      byte_cnt_q  <= '0;
      len_q       <= PAYLOAD_WIDTH'(PKT_MIN_BYTES);
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    byte_cnt_d    = byte_cnt_q;
    len_d         = len_q;
    stall_cnt_d   = stall_cnt_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    pad_pulse_o   = 1'b0;
    frame_end     = 1'b0;

    case (state_q)
      PKT_IDLE: begin
        if (enable_i && s_axis_tvalid) begin
          state_d     = PKT_HDR;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
          len_d       = (payload_bytes_i < PAYLOAD_WIDTH'(PKT_MIN_BYTES)) ?
                        PAYLOAD_WIDTH'(PKT_MIN_BYTES) : payload_bytes_i;
        end
      end

      PKT_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_byte;
        if (m_axis_tready) begin
          byte_cnt_d = byte_cnt_q + PAYLOAD_WIDTH'(1);
          if (byte_cnt_q == PAYLOAD_WIDTH'(PKT_HDR_BYTES - 1)) state_d = PKT_DATA;
        end
      end

      PKT_DATA: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = last_beat;
        if (s_axis_tvalid) begin
          // Downstream backpressure never advances the stall counter.
          stall_cnt_d = '0;
          if (m_axis_tready) begin
            byte_cnt_d = byte_cnt_q + PAYLOAD_WIDTH'(1);
            frame_end  = last_beat;
          end
        end else begin
          stall_cnt_d = stall_cnt_q + TIMEOUT_WIDTH'(1);
          if ((timeout_i != '0) && (stall_cnt_q == timeout_i - TIMEOUT_WIDTH'(1))) begin
            state_d     = PKT_PAD;
            stall_cnt_d = '0;
          end
        end
      end

      PKT_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = last_beat;
        if (m_axis_tready) begin
          byte_cnt_d  = byte_cnt_q + PAYLOAD_WIDTH'(1);
          frame_end   = last_beat;
          pad_pulse_o = last_beat;
        end
      end

      default: state_d = PKT_IDLE;
    endcase

    if (frame_end) begin
      state_d     = PKT_IDLE;
      seq_d       = seq_q + 32'd1;
      byte_cnt_d  = '0;
      stall_cnt_d = '0;
    end
  end

`ifdef PACKETIZER_STATS_EN
  // Completed and padded frame counters, both wrapping at 2^32.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pkt_cnt_o <= '0;
      pad_cnt_o <= '0;
    end else if (frame_end) begin
      pkt_cnt_o <= pkt_cnt_o + 32'd1;
      if (state_q == PKT_PAD) pad_cnt_o <= pad_cnt_o + 32'd1;
    end
  end
`endif

endmodule
